// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, glyph codes and reveal states for the text line sequencer
package text_pkg;

  localparam int MAX_CHARS_DEF = 16;
  localparam int CHAR_W_DEF    = 40;
  localparam int CHAR_H_DEF    = 60;
  localparam int GAP_DEF       = 8;
  localparam int PITCH_DEF     = CHAR_W_DEF + GAP_DEF;

  localparam logic [5:0] ID_BLANK = 6'd63;

  typedef enum logic [5:0] {
    G_0 = 6'd0,  G_1 = 6'd1,  G_2 = 6'd2,  G_3 = 6'd3,  G_4 = 6'd4,
    G_5 = 6'd5,  G_6 = 6'd6,  G_7 = 6'd7,  G_8 = 6'd8,  G_9 = 6'd9,
    G_A = 6'd10, G_B = 6'd11, G_C = 6'd12, G_D = 6'd13, G_E = 6'd14,
    G_F = 6'd15, G_G = 6'd16, G_H = 6'd17, G_I = 6'd18, G_J = 6'd19,
    G_K = 6'd20, G_L = 6'd21, G_DASH = 6'd22,
    G_BLANK = 6'd63
  } glyph_id_e;

  typedef enum logic [1:0] {
    REV_IDLE,
    REV_RUN,
    REV_DONE
  } reveal_state_e;

  function automatic logic [5:0] sat_len(input logic [5:0] len, input int max_chars);
    return (int'(len) > max_chars) ? 6'(max_chars) : len;
  endfunction

endpackage

// File: rtl/reveal_timer.sv
// rtl/reveal_timer.sv - frame counter and IDLE/RUN/DONE typewriter reveal FSM
module reveal_timer
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       restart,
  input  logic [5:0] live_len,
  input  logic [7:0] reveal_period,
  output logic [5:0] shown,
  output logic       reveal_done
);

  reveal_state_e state_q, state_d;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic [5:0]    shown_q, shown_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REV_IDLE;
      cnt_q   <= '0;
      shown_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shown_q <= shown_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shown_d = shown_q;
    cnt_inc = cnt_q + 8'd1;
    if (restart) begin
      state_d = REV_IDLE;
      cnt_d   = '0;
      shown_d = '0;
    end else begin
      case (state_q)
        REV_IDLE: begin
          cnt_d = '0;
          // A zero period or an empty line shows everything straight away.
          if (live_len == 6'd0 || reveal_period == 8'd0) begin
            shown_d = live_len;
            state_d = REV_DONE;
          end else begin
            shown_d = '0;
            state_d = REV_RUN;
          end
        end
        REV_RUN: begin
          if (frame_start) begin
            if (reveal_period == 8'd0) begin
              shown_d = live_len;
            end else if (cnt_inc >= reveal_period) begin
              shown_d = shown_q + 6'd1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          if (shown_d >= live_len) begin
            shown_d = live_len;
            state_d = REV_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign shown       = shown_q;
  assign reveal_done = (state_q == REV_DONE);

endmodule

// File: rtl/text_line_sequencer.sv
// rtl/text_line_sequencer.sv - per-pixel glyph slot scheduler with tear-free commit and reveal
module text_line_sequencer #(
  parameter int         MAX_CHARS = text_pkg::MAX_CHARS_DEF,
  parameter int         CHAR_W    = text_pkg::CHAR_W_DEF,
  parameter int         CHAR_H    = text_pkg::CHAR_H_DEF,
  parameter int         GAP       = text_pkg::GAP_DEF,
  parameter logic [5:0] ID_BLANK  = text_pkg::ID_BLANK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       frame_start,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [5:0] wr_id,
  input  logic       len_wr,
  input  logic [5:0] len_in,
  input  logic       commit,
  input  logic [9:0] origin_x,
  input  logic [8:0] origin_y,
  input  logic [7:0] reveal_period,
  output logic [5:0] glyph_id,
  output logic [9:0] glyph_xstart,
  output logic [8:0] glyph_ystart,
  output logic [6:0] glyph_w,
  output logic [6:0] glyph_h,
  output logic       glyph_valid,
  output logic [9:0] pix_x_q,
  output logic [8:0] pix_y_q,
  output logic       commit_pending,
  output logic       reveal_done
);
  import text_pkg::*;

  localparam int PITCH = CHAR_W + GAP;
  localparam int SW    = $clog2(MAX_CHARS);

  logic [5:0] shadow_q [MAX_CHARS];
  logic [5:0] live_q   [MAX_CHARS];
  logic [5:0] shadow_len_q, live_len_q;
  logic       pending_q;
  logic [9:0] org_x_q;
  logic [8:0] org_y_q;
  logic       apply;
  logic       wr_addr_ok;
  logic [5:0] shown;

  assign apply      = frame_start & pending_q;
  assign wr_addr_ok = ({1'b0, wr_addr} < 6'(MAX_CHARS));

  // The live copy uses the pre-edge shadow, so a same-cycle write stays in shadow only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        shadow_q[i] <= ID_BLANK;
        live_q[i]   <= ID_BLANK;
      end
      shadow_len_q <= '0;
      live_len_q   <= '0;
      pending_q    <= 1'b0;
      org_x_q      <= '0;
      org_y_q      <= '0;
    end else begin
      if (apply) begin
        live_q     <= shadow_q;
        live_len_q <= shadow_len_q;
      end
      if (wr_en && wr_addr_ok) shadow_q[wr_addr[SW-1:0]] <= wr_id;
      if (len_wr) shadow_len_q <= sat_len(len_in, MAX_CHARS);
      if (apply) pending_q <= 1'b0;
      else if (commit) pending_q <= 1'b1;
      if (frame_start) begin
        org_x_q <= origin_x;
        org_y_q <= origin_y;
      end
    end
  end

  reveal_timer u_reveal_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .restart      (apply),
    .live_len     (live_len_q),
    .reveal_period(reveal_period),
    .shown        (shown),
    .reveal_done  (reveal_done)
  );

  logic [10:0] dx, base, rem, y_end;
  logic [5:0]  slot, slot_id;
  logic        x_ok, y_ok, in_buf, hit;

  // Slot index by compare chain against multiples of the cell pitch.
  always_comb begin
    dx   = {1'b0, x} - {1'b0, org_x_q};
    x_ok = (x >= org_x_q);
    slot = '0;
    base = '0;
    for (int i = 1; i <= MAX_CHARS; i++) begin
      if (dx >= 11'(i * PITCH)) begin
        slot = 6'(i);
        base = 11'(i * PITCH);
      end
    end
    rem     = dx - base;
    y_end   = {2'b00, org_y_q} + 11'(CHAR_H);
    y_ok    = (y >= org_y_q) && ({2'b00, y} < y_end);
    in_buf  = (slot < 6'(MAX_CHARS));
    slot_id = in_buf ? live_q[slot[SW-1:0]] : ID_BLANK;
    hit     = x_ok && y_ok && (rem < 11'(CHAR_W)) && in_buf &&
              (slot < live_len_q) && (slot < shown) && (slot_id != ID_BLANK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_id     <= '0;
      glyph_xstart <= '0;
      glyph_ystart <= '0;
      glyph_valid  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
    end else begin
      glyph_valid  <= hit;
      glyph_id     <= hit ? slot_id : 6'd0;
      glyph_xstart <= hit ? 10'({1'b0, org_x_q} + base) : 10'd0;
      glyph_ystart <= hit ? org_y_q : 9'd0;
      pix_x_q      <= x;
      pix_y_q      <= y;
    end
  end

  assign glyph_w        = 7'(CHAR_W);
  assign glyph_h        = 7'(CHAR_H);
  assign commit_pending = pending_q;

endmodule
